// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_pkg
// Brief   : Shared branch_op encodings, branch funct3 codes and counter helpers.
// Revision: 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Must stay aligned with the control-unit branch_op macros.
    localparam logic [1:0] NON_BRANCH = 2'b00;
    localparam logic [1:0] JUMP       = 2'b01;
    localparam logic [1:0] BRANCH     = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weakly-not-taken: one below the MSB-set midpoint, 0 for 1-bit counters.
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_bits);
        if (ctr_bits <= 1)
            return 0;
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_table.sv
`default_nettype none
// ============================================================================
// Module  : bht_table
// Brief   : 2^IDX_BITS x CTR_BITS saturating counter array, async read port.
// Revision: 1.0 - initial release
// ============================================================================
module bht_table
    import branch_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [CTR_BITS-1:0] rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_taken_i
);

    localparam int                c_depth     = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] c_ctr_reset = CTR_BITS'(ctr_reset_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] c_ctr_max   = '1;

    logic [CTR_BITS-1:0] r_table [c_depth];
    logic [CTR_BITS-1:0] w_cur;
    logic [CTR_BITS-1:0] w_next;

    // No bypass: a same-index write this cycle is seen by the reader next cycle.
    assign rd_ctr_o = r_table[rd_idx_i];

    always_comb begin
        w_cur  = r_table[wr_idx_i];
        w_next = w_cur;
        if (wr_taken_i) begin
            if (w_cur != c_ctr_max)
                w_next = w_cur + CTR_BITS'(1);
        end else begin
            if (w_cur != '0)
                w_next = w_cur - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < c_depth; i++)
                r_table[i] <= c_ctr_reset;
        end else if (wr_en_i) begin
            r_table[wr_idx_i] <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_prediction_unit.sv
`default_nettype none
// ============================================================================
// Module  : branch_prediction_unit
// Brief   : Fetch-side direction prediction, execute-side resolution/training.
// Revision: 1.0 - initial release
// ============================================================================
module branch_prediction_unit
    import branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_BITS  = 6,
    parameter int CTR_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [WIDTH-1:0]     pc_f_i,
    output logic                 pred_taken_f_o,
    input  logic                 valid_e_i,
    input  logic [WIDTH-1:0]     pc_e_i,
    input  logic [2:0]           funct3_i,
    input  logic [1:0]           branch_op_i,
    input  logic                 pred_taken_e_i,
    input  logic                 neg_flag_i,
    input  logic                 zero_flag_i,
    input  logic                 carry_flag_i,
    input  logic                 v_flag_i,
    output logic                 pc_src_res_o,
    output logic                 mispredict_o,
    output logic [STAT_BITS-1:0] branch_count_o,
    output logic [STAT_BITS-1:0] mispredict_count_o
);

    logic [IDX_BITS-1:0]  w_idx_f;
    logic [IDX_BITS-1:0]  w_idx_e;
    logic [CTR_BITS-1:0]  w_ctr_f;
    logic                 w_res;
    logic                 w_is_ctl;
    logic                 w_mispredict;
    logic                 w_update;
    logic                 w_unused;
    logic [STAT_BITS-1:0] r_branch_count;
    logic [STAT_BITS-1:0] r_mispredict_count;

    // Word-aligned PCs: bits [1:0] and everything above the index alias freely.
    assign w_idx_f  = pc_f_i[IDX_BITS+1:2];
    assign w_idx_e  = pc_e_i[IDX_BITS+1:2];
    assign w_unused = ^{pc_f_i[WIDTH-1:IDX_BITS+2], pc_f_i[1:0],
                        pc_e_i[WIDTH-1:IDX_BITS+2], pc_e_i[1:0]};

    bht_table #(
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_bht_table (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_idx_i   (w_idx_f),
        .rd_ctr_o   (w_ctr_f),
        .wr_en_i    (w_update),
        .wr_idx_i   (w_idx_e),
        .wr_taken_i (w_res)
    );

    assign pred_taken_f_o = w_ctr_f[CTR_BITS-1];

    always_comb begin
        w_res = 1'b0;
        case (branch_op_i)
            BRANCH: begin
                case (funct3_i)
                    F3_BEQ:  w_res = zero_flag_i;
                    F3_BNE:  w_res = ~zero_flag_i;
                    F3_BLT:  w_res = neg_flag_i ^ v_flag_i;
                    F3_BGE:  w_res = ~(neg_flag_i ^ v_flag_i);
                    F3_BLTU: w_res = ~carry_flag_i;
                    F3_BGEU: w_res = carry_flag_i;
                    default: w_res = 1'b0;
                endcase
            end
            JUMP:    w_res = 1'b1;
            default: w_res = 1'b0;
        endcase
    end

    assign w_is_ctl     = (branch_op_i == BRANCH) || (branch_op_i == JUMP);
    assign w_mispredict = valid_e_i & w_is_ctl & (w_res != pred_taken_e_i);
    // Jumps flush on mispredict but never train or count.
    assign w_update     = valid_e_i & (branch_op_i == BRANCH);

    assign pc_src_res_o = w_res;
    assign mispredict_o = w_mispredict;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_update) begin
            if (r_branch_count != '1)
                r_branch_count <= r_branch_count + STAT_BITS'(1);
            if (w_mispredict && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + STAT_BITS'(1);
        end
    end

    assign branch_count_o     = r_branch_count;
    assign mispredict_count_o = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_prediction_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_prediction_unit
// Brief   : Directed, table-driven self-checking bench for branch_prediction_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_prediction_unit;

    localparam logic [1:0] OP_NB = 2'b00;
    localparam logic [1:0] OP_J  = 2'b01;
    localparam logic [1:0] OP_B  = 2'b10;
    localparam logic [1:0] OP_X  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_f;
    logic        valid_e;
    logic [31:0] pc_e;
    logic [2:0]  funct3;
    logic [1:0]  branch_op;
    logic        pred_e;
    logic        n_f, z_f, c_f, v_f;
    logic        res;
    logic        mis;
    logic [3:0]  bcount;
    logic [3:0]  mcount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_prediction_unit #(
        .WIDTH     (32),
        .IDX_BITS  (6),
        .CTR_BITS  (2),
        .STAT_BITS (4)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .pc_f_i             (pc_f),
        .pred_taken_f_o     (pred_f),
        .valid_e_i          (valid_e),
        .pc_e_i             (pc_e),
        .funct3_i           (funct3),
        .branch_op_i        (branch_op),
        .pred_taken_e_i     (pred_e),
        .neg_flag_i         (n_f),
        .zero_flag_i        (z_f),
        .carry_flag_i       (c_f),
        .v_flag_i           (v_f),
        .pc_src_res_o       (res),
        .mispredict_o       (mis),
        .branch_count_o     (bcount),
        .mispredict_count_o (mcount)
    );

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [2:0] f3;
        logic       n, z, c, v;
        logic       pred;
        logic       valid;
        logic       exp_res;
        logic       exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic [1:0] op, logic [2:0] f3,
                                logic n, logic z, logic c, logic v,
                                logic pred, logic valid, logic er, logic em);
        vec_t t;
        t.name = name; t.op = op; t.f3 = f3;
        t.n = n; t.z = z; t.c = c; t.v = v;
        t.pred = pred; t.valid = valid; t.exp_res = er; t.exp_mis = em;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                          input logic pred, input logic valid);
        branch_op = op; funct3 = f3; pc_e = pc; pred_e = pred; valid_e = valid;
    endtask

    initial begin
        reset = 1'b1; pc_f = '0; valid_e = 1'b0; pc_e = '0; funct3 = '0;
        branch_op = OP_NB; pred_e = 1'b0; {n_f, z_f, c_f, v_f} = 4'b0000;

        //        name        op     f3      n  z  c  v  pd vl res mis
        add("beq_t",    OP_B, 3'b000, 0, 1, 0, 0, 0, 1, 1, 1);
        add("beq_nt",   OP_B, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0);
        add("bne_t",    OP_B, 3'b001, 0, 0, 0, 0, 1, 1, 1, 0);
        add("bne_nt",   OP_B, 3'b001, 0, 1, 0, 0, 1, 1, 0, 1);
        add("blt_t",    OP_B, 3'b100, 1, 0, 0, 0, 0, 1, 1, 1);
        add("blt_nt",   OP_B, 3'b100, 1, 0, 0, 1, 0, 1, 0, 0);
        add("bge_nt",   OP_B, 3'b101, 1, 0, 0, 0, 1, 1, 0, 1);
        add("bge_t",    OP_B, 3'b101, 0, 0, 0, 0, 1, 1, 1, 0);
        add("bltu_t",   OP_B, 3'b110, 0, 0, 0, 0, 1, 1, 1, 0);
        add("bltu_nt",  OP_B, 3'b110, 0, 0, 1, 0, 1, 1, 0, 1);
        add("bgeu_t",   OP_B, 3'b111, 0, 0, 1, 0, 0, 1, 1, 1);
        add("bgeu_nt",  OP_B, 3'b111, 0, 0, 0, 0, 0, 1, 0, 0);
        add("bad_f3",   OP_B, 3'b010, 0, 1, 1, 0, 1, 1, 0, 1);
        add("jump_mis", OP_J, 3'b000, 0, 0, 0, 0, 0, 1, 1, 1);
        add("jump_ok",  OP_J, 3'b000, 0, 0, 0, 0, 1, 1, 1, 0);
        add("nonbr",    OP_NB,3'b000, 0, 1, 0, 0, 1, 1, 0, 0);
        add("op_11",    OP_X, 3'b000, 0, 1, 1, 0, 1, 1, 0, 0);
        add("beq_inv",  OP_B, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0);

        step(); step();
        // Resolution is combinational and holding reset blocks any training.
        foreach (vecs[i]) begin
            set_br(vecs[i].op, vecs[i].f3, 32'h40, vecs[i].pred, vecs[i].valid);
            {n_f, z_f, c_f, v_f} = {vecs[i].n, vecs[i].z, vecs[i].c, vecs[i].v};
            pc_f = 32'h40;
            #1;
            check({vecs[i].name, "_res"}, 32'(res), 32'(vecs[i].exp_res));
            check({vecs[i].name, "_mis"}, 32'(mis), 32'(vecs[i].exp_mis));
            check({vecs[i].name, "_pf_rst"}, 32'(pred_f), 32'd0);
        end
        valid_e = 1'b0;
        step();
        reset = 1'b0;
        #1;

        // Reset state: all entries not-taken, counters clear.
        for (int i = 0; i < 64; i++) begin
            pc_f = 32'(i) << 2;
            #1;
            check($sformatf("rst_pred_%0d", i), 32'(pred_f), 32'd0);
        end
        check("rst_bcount", 32'(bcount), 32'd0);
        check("rst_mcount", 32'(mcount), 32'd0);

        // BEQ taken at 0x40 with predicted not-taken.
        set_br(OP_B, 3'b000, 32'h40, 1'b0, 1'b1);
        {n_f, z_f, c_f, v_f} = 4'b0100;
        pc_f = 32'h40;
        #1;
        check("beq40_res", 32'(res), 32'd1);
        check("beq40_mis", 32'(mis), 32'd1);
        check("beq40_pf_old", 32'(pred_f), 32'd0);
        step();
        valid_e = 1'b0;
        #1;
        check("beq40_pf_new", 32'(pred_f), 32'd1);
        pc_f = 32'h140;
        #1;
        check("alias140_pf", 32'(pred_f), 32'd1);
        check("beq40_bcount", 32'(bcount), 32'd1);
        check("beq40_mcount", 32'(mcount), 32'd1);

        // Index 5: four taken BLTU (C=0) saturate at 3, then two not-taken.
        pc_f = 32'h14;
        {n_f, z_f, c_f, v_f} = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            set_br(OP_B, 3'b110, 32'h14, 1'b1, 1'b1);
            step();
        end
        valid_e = 1'b0;
        #1;
        check("sat_pf_3", 32'(pred_f), 32'd1);
        c_f = 1'b1;
        set_br(OP_B, 3'b110, 32'h14, 1'b1, 1'b1);
        step();
        valid_e = 1'b0;
        #1;
        check("sat_pf_2", 32'(pred_f), 32'd1);
        set_br(OP_B, 3'b110, 32'h14, 1'b1, 1'b1);
        step();
        valid_e = 1'b0;
        #1;
        check("sat_pf_1", 32'(pred_f), 32'd0);
        check("sat_bcount", 32'(bcount), 32'd7);
        check("sat_mcount", 32'(mcount), 32'd3);

        // JUMP neither trains nor counts.
        pc_f = 32'h80;
        set_br(OP_J, 3'b000, 32'h80, 1'b0, 1'b1);
        #1;
        check("jump_mis_seq", 32'(mis), 32'd1);
        step();
        valid_e = 1'b0;
        #1;
        check("jump_pf", 32'(pred_f), 32'd0);
        check("jump_bcount", 32'(bcount), 32'd7);
        check("jump_mcount", 32'(mcount), 32'd3);

        // Same-index read/write: old value this cycle, new value next cycle.
        pc_f = 32'h200;
        {n_f, z_f, c_f, v_f} = 4'b0100;
        set_br(OP_B, 3'b000, 32'h200, 1'b1, 1'b1);
        #1;
        check("bypass_old", 32'(pred_f), 32'd0);
        step();
        valid_e = 1'b0;
        #1;
        check("bypass_new", 32'(pred_f), 32'd1);
        // Not-taken with valid low must not decrement the counter back to 1.
        z_f = 1'b0;
        set_br(OP_B, 3'b000, 32'h200, 1'b0, 1'b0);
        step(); step();
        check("stall_pf", 32'(pred_f), 32'd1);
        check("stall_bcount", 32'(bcount), 32'd8);
        check("stall_mcount", 32'(mcount), 32'd3);

        // Clear, then 20 mispredicted branches must pin both counters at F.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("clr_bcount", 32'(bcount), 32'd0);
        z_f = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_br(OP_B, 3'b000, 32'h300, 1'b0, 1'b1);
            step();
        end
        check("stat_bcount_sat", 32'(bcount), 32'hF);
        check("stat_mcount_sat", 32'(mcount), 32'hF);
        pc_f = 32'h300;
        #1;
        check("stat_pf_idx0", 32'(pred_f), 32'd1);

        // Reset wins over a concurrent qualifying update.
        reset = 1'b1;
        set_br(OP_B, 3'b000, 32'h300, 1'b0, 1'b1);
        step();
        check("midrst_bcount", 32'(bcount), 32'd0);
        check("midrst_mcount", 32'(mcount), 32'd0);
        check("midrst_pf_idx0", 32'(pred_f), 32'd0);
        pc_f = 32'h40;
        #1;
        check("midrst_pf_idx16", 32'(pred_f), 32'd0);
        reset = 1'b0;
        valid_e = 1'b0;
        step();
        check("post_rst_bcount", 32'(bcount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
